// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter:
//   - datapath widths
//   - OP_* opcode constants
//   - flag bit indices. The flags word is {negative, overflow, carry, zero}.
//   - the port identifier type used for grant tracking
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR = 4'h4;
  localparam logic [OP_W-1:0] OP_NOT = 4'h5;
  localparam logic [OP_W-1:0] OP_SHL = 4'h6;
  localparam logic [OP_W-1:0] OP_SHR = 4'h7;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the two client ports of alu_arbiter.
//
// Signals, repeated for ports 0 and 1:
//   reqN_valid / reqN_ready           request handshake
//   reqN_op, reqN_a, reqN_b           request payload
//   rspN_valid / rspN_ready           response handshake
//   rspN_result, rspN_flags           response payload
//
// Modports:
//   slave  - the arbiter side
//   master - the client/driver side
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic [FLAG_W-1:0] rsp0_flags;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic [FLAG_W-1:0] rsp1_flags;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_flags,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_flags
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_flags,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_flags
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU shared by both arbiter ports.
//
// Ports:
//   i_op     opcode (OP_*)
//   i_a      first operand
//   i_b      second operand
//   o_result result
//   o_flags  {negative, overflow, carry, zero}
//
// Opcode behaviour:
//   - SUB carry is the inverse of borrow.
//   - Shifts report the bit that was shifted out as carry.
//   - Unknown opcodes produce a zero result.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic [FLAG_W-1:0] o_flags
);

  logic [DATA_W:0] w_wide;
  logic            w_carry;
  logic            w_ovf;

  always_comb begin
    w_wide  = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_wide  = {1'b0, i_a} + {1'b0, i_b};
        w_carry = w_wide[DATA_W];
        w_ovf   = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                  (w_wide[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_SUB: begin
        w_wide  = {1'b0, i_a} - {1'b0, i_b};
        w_carry = ~w_wide[DATA_W];
        w_ovf   = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                  (w_wide[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_AND: w_wide = {1'b0, i_a & i_b};
      OP_OR:  w_wide = {1'b0, i_a | i_b};
      OP_XOR: w_wide = {1'b0, i_a ^ i_b};
      OP_NOT: w_wide = {1'b0, ~i_a};
      OP_SHL: begin
        w_wide  = {i_a, 1'b0};
        w_carry = i_a[DATA_W-1];
      end
      OP_SHR: begin
        w_wide  = {2'b00, i_a[DATA_W-1:1]};
        w_carry = i_a[0];
      end
      default: w_wide = '0;
    endcase
  end

  always_comb begin
    o_result         = w_wide[DATA_W-1:0];
    o_flags          = '0;
    o_flags[FLAG_N]  = w_wide[DATA_W-1];
    o_flags[FLAG_V]  = w_ovf;
    o_flags[FLAG_C]  = w_carry;
    o_flags[FLAG_Z]  = (w_wide[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single shared ALU.
// Only one operation is in flight at a time, so peak throughput is one
// operation every three cycles:
//   1. IDLE: grant a port and latch its request.
//   2. EXEC: capture the ALU output into the granted port's response
//      registers.
//   3. RESP: hold the response until the client consumes it.
//
// Parameters:
//   FIXED_PRIO  0 = round-robin on ties, 1 = port 0 always wins.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset. Reset aborts any in-flight
//         operation.
//   bus   alu_arbiter_if.slave (request/response for ports 0 and 1)
//   busy  high whenever the FSM is not IDLE
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  port_id_t          r_last_grant;
  port_id_t          r_gnt_id;
  port_id_t          w_gnt_id;

  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;

  logic              r_rsp0_valid;
  logic [DATA_W-1:0] r_rsp0_result;
  logic [FLAG_W-1:0] r_rsp0_flags;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp1_result;
  logic [FLAG_W-1:0] r_rsp1_flags;

  logic              w_any_valid;
  logic              w_accept;
  logic              w_rsp_fire;
  logic [DATA_W-1:0] w_alu_result;
  logic [FLAG_W-1:0] w_alu_flags;

  alu_arbiter_alu u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  // Grant selection.
  // On a tie in round-robin mode, the port that did not win last time
  // takes the grant.
  always_comb begin
    w_gnt_id = PORT0;
    if (bus.req0_valid && bus.req1_valid) begin
      if (FIXED_PRIO) begin
        w_gnt_id = PORT0;
      end else begin
        w_gnt_id = (r_last_grant == PORT0) ? PORT1 : PORT0;
      end
    end else if (bus.req1_valid) begin
      w_gnt_id = PORT1;
    end
  end

  assign w_any_valid = bus.req0_valid | bus.req1_valid;
  assign w_accept    = (r_state == ST_IDLE) && w_any_valid && !rst;

  assign bus.req0_ready = w_accept && (w_gnt_id == PORT0);
  assign bus.req1_ready = w_accept && (w_gnt_id == PORT1);

  // Only the granted port's ready can retire the response.
  // A ready on the other port, or a ready seen while rsp_valid is low,
  // has no effect.
  assign w_rsp_fire = (r_gnt_id == PORT0) ? (r_rsp0_valid && bus.rsp0_ready)
                                          : (r_rsp1_valid && bus.rsp1_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_next = ST_EXEC;
      ST_EXEC:                 w_next = ST_RESP;
      ST_RESP: if (w_rsp_fire) w_next = ST_IDLE;
      default:                 w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant  <= PORT1;
      r_gnt_id      <= PORT0;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_flags  <= '0;
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_gnt_id     <= w_gnt_id;
        r_last_grant <= w_gnt_id;
        r_op         <= (w_gnt_id == PORT0) ? bus.req0_op : bus.req1_op;
        r_a          <= (w_gnt_id == PORT0) ? bus.req0_a  : bus.req1_a;
        r_b          <= (w_gnt_id == PORT0) ? bus.req0_b  : bus.req1_b;
      end
      if (r_state == ST_EXEC) begin
        if (r_gnt_id == PORT0) begin
          r_rsp0_valid  <= 1'b1;
          r_rsp0_result <= w_alu_result;
          r_rsp0_flags  <= w_alu_flags;
        end else begin
          r_rsp1_valid  <= 1'b1;
          r_rsp1_result <= w_alu_result;
          r_rsp1_flags  <= w_alu_flags;
        end
      end
      // Clearing the payload along with valid means an idle port always
      // reads as zero.
      if ((r_state == ST_RESP) && w_rsp_fire) begin
        r_rsp0_valid  <= 1'b0;
        r_rsp0_result <= '0;
        r_rsp0_flags  <= '0;
        r_rsp1_valid  <= 1'b0;
        r_rsp1_result <= '0;
        r_rsp1_flags  <= '0;
      end
    end
  end

  assign bus.rsp0_valid  = r_rsp0_valid;
  assign bus.rsp0_result = r_rsp0_result;
  assign bus.rsp0_flags  = r_rsp0_flags;
  assign bus.rsp1_valid  = r_rsp1_valid;
  assign bus.rsp1_result = r_rsp1_result;
  assign bus.rsp1_flags  = r_rsp1_flags;

  assign busy = (r_state != ST_IDLE);

endmodule
